// File: rtl/ysyx_24100029_xbar.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_xbar
//
// AXI4 1-to-2 crossbar sitting directly upstream of the CLINT. The core's
// single AXI4 master port (in_*) is routed either to the CLINT slave
// (clint_*) or to the default SoC slave (soc_*), and responses are muxed
// back. At most one read and one write are outstanding. Read and write sides
// are independent FSMs.
//
// Region decode: an address hits the CLINT when
//     (addr & CLINT_MASK) == CLINT_BASE
//
// The single-beat CLINT does not drive rlast/rid, so on CLINT reads the
// crossbar returns rlast=1 and rid=latched arid instead.
//
// Optional feature macro: YSYX_24100029_CLINT_WPROT_EN
//     When defined, writes that hit the CLINT region are accepted locally,
//     their data beats are sunk and SLVERR (2'b10) is returned through a
//     registered B response. The CLINT never sees a write.
//     When undefined, CLINT-region writes are forwarded to clint_*.
//
// Ports:
//     clock, reset         clock and synchronous active-high reset
//     in_ar*/in_r*         upstream read address / read data channels
//     in_aw*/in_w*/in_b*   upstream write address / data / response channels
//     clint_*              master port towards the CLINT
//     soc_*                master port towards the default SoC slave
//                          (clint_rlast_i and clint_rid_i are ignored)
// ----------------------------------------------------------------------------
module ysyx_24100029_xbar (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] in_araddr_i,
    input  logic        in_arvalid_i,
    input  logic [3:0]  in_arid_i,
    input  logic [7:0]  in_arlen_i,
    input  logic [2:0]  in_arsize_i,
    input  logic [1:0]  in_arburst_i,
    output logic        in_arready_o,
    output logic [31:0] in_rdata_o,
    output logic [1:0]  in_rresp_o,
    output logic        in_rvalid_o,
    output logic        in_rlast_o,
    output logic [3:0]  in_rid_o,
    input  logic        in_rready_i,
    input  logic [31:0] in_awaddr_i,
    input  logic        in_awvalid_i,
    input  logic [3:0]  in_awid_i,
    input  logic [7:0]  in_awlen_i,
    input  logic [2:0]  in_awsize_i,
    input  logic [1:0]  in_awburst_i,
    output logic        in_awready_o,
    input  logic [31:0] in_wdata_i,
    input  logic [3:0]  in_wstrb_i,
    input  logic        in_wvalid_i,
    input  logic        in_wlast_i,
    output logic        in_wready_o,
    output logic [1:0]  in_bresp_o,
    output logic        in_bvalid_o,
    output logic [3:0]  in_bid_o,
    input  logic        in_bready_i,

    output logic [31:0] clint_araddr_o,
    output logic        clint_arvalid_o,
    output logic [3:0]  clint_arid_o,
    output logic [7:0]  clint_arlen_o,
    output logic [2:0]  clint_arsize_o,
    output logic [1:0]  clint_arburst_o,
    input  logic        clint_arready_i,
    input  logic [31:0] clint_rdata_i,
    input  logic [1:0]  clint_rresp_i,
    input  logic        clint_rvalid_i,
    input  logic        clint_rlast_i,
    input  logic [3:0]  clint_rid_i,
    output logic        clint_rready_o,
    output logic [31:0] clint_awaddr_o,
    output logic        clint_awvalid_o,
    output logic [3:0]  clint_awid_o,
    output logic [7:0]  clint_awlen_o,
    output logic [2:0]  clint_awsize_o,
    output logic [1:0]  clint_awburst_o,
    input  logic        clint_awready_i,
    output logic [31:0] clint_wdata_o,
    output logic [3:0]  clint_wstrb_o,
    output logic        clint_wvalid_o,
    output logic        clint_wlast_o,
    input  logic        clint_wready_i,
    input  logic [1:0]  clint_bresp_i,
    input  logic        clint_bvalid_i,
    input  logic [3:0]  clint_bid_i,
    output logic        clint_bready_o,

    output logic [31:0] soc_araddr_o,
    output logic        soc_arvalid_o,
    output logic [3:0]  soc_arid_o,
    output logic [7:0]  soc_arlen_o,
    output logic [2:0]  soc_arsize_o,
    output logic [1:0]  soc_arburst_o,
    input  logic        soc_arready_i,
    input  logic [31:0] soc_rdata_i,
    input  logic [1:0]  soc_rresp_i,
    input  logic        soc_rvalid_i,
    input  logic        soc_rlast_i,
    input  logic [3:0]  soc_rid_i,
    output logic        soc_rready_o,
    output logic [31:0] soc_awaddr_o,
    output logic        soc_awvalid_o,
    output logic [3:0]  soc_awid_o,
    output logic [7:0]  soc_awlen_o,
    output logic [2:0]  soc_awsize_o,
    output logic [1:0]  soc_awburst_o,
    input  logic        soc_awready_i,
    output logic [31:0] soc_wdata_o,
    output logic [3:0]  soc_wstrb_o,
    output logic        soc_wvalid_o,
    output logic        soc_wlast_o,
    input  logic        soc_wready_i,
    input  logic [1:0]  soc_bresp_i,
    input  logic        soc_bvalid_i,
    input  logic [3:0]  soc_bid_i,
    output logic        soc_bready_o
);

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_CLINT = 2'd1,
        R_SOC   = 2'd2
    } rState_e;

`ifdef YSYX_24100029_CLINT_WPROT_EN
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_CLINT = 2'd1,
        W_SOC   = 2'd2,
        W_ERR   = 2'd3
    } wState_e;
`else
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_CLINT = 2'd1,
        W_SOC   = 2'd2
    } wState_e;
`endif

    rState_e     rState_q, rState_d;
    wState_e     wState_q, wState_d;
    logic [3:0]  arId_q, arId_d;
    logic [3:0]  awId_q, awId_d;
    logic        arHitClint;
    logic        awHitClint;
    logic        run;

    // The CLINT is single-beat and leaves these undriven in practice.
    logic        unusedClintR;
    assign unusedClintR = clint_rlast_i ^ (^clint_rid_i);

    // Every handshake-qualifying output is forced low while reset is held,
    // including the combinational idle-state readys.
    assign run        = ~reset;
    assign arHitClint = (in_araddr_i & CLINT_MASK) == CLINT_BASE;
    assign awHitClint = (in_awaddr_i & CLINT_MASK) == CLINT_BASE;

    // Address and data payloads are broadcast; only the valids are steered.
    assign clint_araddr_o  = in_araddr_i;
    assign clint_arid_o    = in_arid_i;
    assign clint_arlen_o   = in_arlen_i;
    assign clint_arsize_o  = in_arsize_i;
    assign clint_arburst_o = in_arburst_i;
    assign soc_araddr_o    = in_araddr_i;
    assign soc_arid_o      = in_arid_i;
    assign soc_arlen_o     = in_arlen_i;
    assign soc_arsize_o    = in_arsize_i;
    assign soc_arburst_o   = in_arburst_i;
    assign clint_awaddr_o  = in_awaddr_i;
    assign clint_awid_o    = in_awid_i;
    assign clint_awlen_o   = in_awlen_i;
    assign clint_awsize_o  = in_awsize_i;
    assign clint_awburst_o = in_awburst_i;
    assign soc_awaddr_o    = in_awaddr_i;
    assign soc_awid_o      = in_awid_i;
    assign soc_awlen_o     = in_awlen_i;
    assign soc_awsize_o    = in_awsize_i;
    assign soc_awburst_o   = in_awburst_i;
    assign clint_wdata_o   = in_wdata_i;
    assign clint_wstrb_o   = in_wstrb_i;
    assign clint_wlast_o   = in_wlast_i;
    assign soc_wdata_o     = in_wdata_i;
    assign soc_wstrb_o     = in_wstrb_i;
    assign soc_wlast_o     = in_wlast_i;

    // ------------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rState_q <= R_IDLE;
            arId_q   <= '0;
        end else begin
            rState_q <= rState_d;
            arId_q   <= arId_d;
        end
    end

    always_comb begin
        rState_d        = rState_q;
        arId_d          = arId_q;
        in_arready_o    = 1'b0;
        clint_arvalid_o = 1'b0;
        soc_arvalid_o   = 1'b0;
        in_rdata_o      = '0;
        in_rresp_o      = '0;
        in_rvalid_o     = 1'b0;
        in_rlast_o      = 1'b0;
        in_rid_o        = '0;
        clint_rready_o  = 1'b0;
        soc_rready_o    = 1'b0;
        case (rState_q)
            R_IDLE: begin
                if (arHitClint) begin
                    clint_arvalid_o = in_arvalid_i & run;
                    in_arready_o    = clint_arready_i & run;
                end else begin
                    soc_arvalid_o   = in_arvalid_i & run;
                    in_arready_o    = soc_arready_i & run;
                end
                if (in_arvalid_i && in_arready_o) begin
                    arId_d   = in_arid_i;
                    rState_d = arHitClint ? R_CLINT : R_SOC;
                end
            end
            R_CLINT: begin
                in_rdata_o     = clint_rdata_i;
                in_rresp_o     = clint_rresp_i;
                in_rvalid_o    = clint_rvalid_i & run;
                in_rlast_o     = 1'b1;
                in_rid_o       = arId_q;
                clint_rready_o = in_rready_i & run;
                if (in_rvalid_o && in_rready_i) begin
                    rState_d = R_IDLE;
                end
            end
            R_SOC: begin
                in_rdata_o   = soc_rdata_i;
                in_rresp_o   = soc_rresp_i;
                in_rvalid_o  = soc_rvalid_i & run;
                in_rlast_o   = soc_rlast_i;
                in_rid_o     = soc_rid_i;
                soc_rready_o = in_rready_i & run;
                if (in_rvalid_o && in_rready_i && in_rlast_o) begin
                    rState_d = R_IDLE;
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------------
`ifdef YSYX_24100029_CLINT_WPROT_EN
    // Registered SLVERR response for writes sunk locally.
    logic errBvalid_q, errBvalid_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            errBvalid_q <= 1'b0;
        end else begin
            errBvalid_q <= errBvalid_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            wState_q <= W_IDLE;
            awId_q   <= '0;
        end else begin
            wState_q <= wState_d;
            awId_q   <= awId_d;
        end
    end

    always_comb begin
        wState_d        = wState_q;
        awId_d          = awId_q;
`ifdef YSYX_24100029_CLINT_WPROT_EN
        errBvalid_d     = errBvalid_q;
`endif
        in_awready_o    = 1'b0;
        clint_awvalid_o = 1'b0;
        soc_awvalid_o   = 1'b0;
        in_wready_o     = 1'b0;
        clint_wvalid_o  = 1'b0;
        soc_wvalid_o    = 1'b0;
        in_bresp_o      = '0;
        in_bvalid_o     = 1'b0;
        in_bid_o        = '0;
        clint_bready_o  = 1'b0;
        soc_bready_o    = 1'b0;
        case (wState_q)
            W_IDLE: begin
                if (awHitClint) begin
`ifdef YSYX_24100029_CLINT_WPROT_EN
                    in_awready_o    = run;
`else
                    clint_awvalid_o = in_awvalid_i & run;
                    in_awready_o    = clint_awready_i & run;
`endif
                end else begin
                    soc_awvalid_o   = in_awvalid_i & run;
                    in_awready_o    = soc_awready_i & run;
                end
                if (in_awvalid_i && in_awready_o) begin
                    awId_d = in_awid_i;
`ifdef YSYX_24100029_CLINT_WPROT_EN
                    wState_d = awHitClint ? W_ERR : W_SOC;
`else
                    wState_d = awHitClint ? W_CLINT : W_SOC;
`endif
                end
            end
            W_CLINT: begin
                clint_wvalid_o = in_wvalid_i & run;
                in_wready_o    = clint_wready_i & run;
                in_bresp_o     = clint_bresp_i;
                in_bvalid_o    = clint_bvalid_i & run;
                in_bid_o       = clint_bid_i;
                clint_bready_o = in_bready_i & run;
                if (in_bvalid_o && in_bready_i) begin
                    wState_d = W_IDLE;
                end
            end
            W_SOC: begin
                soc_wvalid_o = in_wvalid_i & run;
                in_wready_o  = soc_wready_i & run;
                in_bresp_o   = soc_bresp_i;
                in_bvalid_o  = soc_bvalid_i & run;
                in_bid_o     = soc_bid_i;
                soc_bready_o = in_bready_i & run;
                if (in_bvalid_o && in_bready_i) begin
                    wState_d = W_IDLE;
                end
            end
`ifdef YSYX_24100029_CLINT_WPROT_EN
            W_ERR: begin
                // Beats are sunk until the last one; the response then
                // appears one cycle later and waits for bready.
                in_wready_o = ~errBvalid_q & run;
                in_bresp_o  = 2'b10;
                in_bvalid_o = errBvalid_q & run;
                in_bid_o    = awId_q;
                if (in_wvalid_i && in_wready_o && in_wlast_i) begin
                    errBvalid_d = 1'b1;
                end
                if (in_bvalid_o && in_bready_i) begin
                    errBvalid_d = 1'b0;
                    wState_d    = W_IDLE;
                end
            end
`endif
            default: wState_d = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100029_xbar.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24100029_xbar
//
// Directed testbench for the AXI4 1-to-2 crossbar. The bench plays both the
// upstream master and the two slaves, driving inputs one time unit after the
// rising edge and sampling the combinational outputs two units later.
// ----------------------------------------------------------------------------
module tb_ysyx_24100029_xbar;

    logic        clock;
    logic        reset;
    logic [31:0] in_araddr;
    logic        in_arvalid;
    logic [3:0]  in_arid;
    logic [7:0]  in_arlen;
    logic [2:0]  in_arsize;
    logic [1:0]  in_arburst;
    logic        in_arready;
    logic [31:0] in_rdata;
    logic [1:0]  in_rresp;
    logic        in_rvalid;
    logic        in_rlast;
    logic [3:0]  in_rid;
    logic        in_rready;
    logic [31:0] in_awaddr;
    logic        in_awvalid;
    logic [3:0]  in_awid;
    logic [7:0]  in_awlen;
    logic [2:0]  in_awsize;
    logic [1:0]  in_awburst;
    logic        in_awready;
    logic [31:0] in_wdata;
    logic [3:0]  in_wstrb;
    logic        in_wvalid;
    logic        in_wlast;
    logic        in_wready;
    logic [1:0]  in_bresp;
    logic        in_bvalid;
    logic [3:0]  in_bid;
    logic        in_bready;

    logic [31:0] clint_araddr, soc_araddr;
    logic        clint_arvalid, soc_arvalid;
    logic [3:0]  clint_arid, soc_arid;
    logic [7:0]  clint_arlen, soc_arlen;
    logic [2:0]  clint_arsize, soc_arsize;
    logic [1:0]  clint_arburst, soc_arburst;
    logic        clint_arready, soc_arready;
    logic [31:0] clint_rdata, soc_rdata;
    logic [1:0]  clint_rresp, soc_rresp;
    logic        clint_rvalid, soc_rvalid;
    logic        clint_rlast, soc_rlast;
    logic [3:0]  clint_rid, soc_rid;
    logic        clint_rready, soc_rready;
    logic [31:0] clint_awaddr, soc_awaddr;
    logic        clint_awvalid, soc_awvalid;
    logic [3:0]  clint_awid, soc_awid;
    logic [7:0]  clint_awlen, soc_awlen;
    logic [2:0]  clint_awsize, soc_awsize;
    logic [1:0]  clint_awburst, soc_awburst;
    logic        clint_awready, soc_awready;
    logic [31:0] clint_wdata, soc_wdata;
    logic [3:0]  clint_wstrb, soc_wstrb;
    logic        clint_wvalid, soc_wvalid;
    logic        clint_wlast, soc_wlast;
    logic        clint_wready, soc_wready;
    logic [1:0]  clint_bresp, soc_bresp;
    logic        clint_bvalid, soc_bvalid;
    logic [3:0]  clint_bid, soc_bid;
    logic        clint_bready, soc_bready;

    int checks;
    int failures;

    ysyx_24100029_xbar dut (
        .clock(clock), .reset(reset),
        .in_araddr_i(in_araddr), .in_arvalid_i(in_arvalid), .in_arid_i(in_arid),
        .in_arlen_i(in_arlen), .in_arsize_i(in_arsize), .in_arburst_i(in_arburst),
        .in_arready_o(in_arready),
        .in_rdata_o(in_rdata), .in_rresp_o(in_rresp), .in_rvalid_o(in_rvalid),
        .in_rlast_o(in_rlast), .in_rid_o(in_rid), .in_rready_i(in_rready),
        .in_awaddr_i(in_awaddr), .in_awvalid_i(in_awvalid), .in_awid_i(in_awid),
        .in_awlen_i(in_awlen), .in_awsize_i(in_awsize), .in_awburst_i(in_awburst),
        .in_awready_o(in_awready),
        .in_wdata_i(in_wdata), .in_wstrb_i(in_wstrb), .in_wvalid_i(in_wvalid),
        .in_wlast_i(in_wlast), .in_wready_o(in_wready),
        .in_bresp_o(in_bresp), .in_bvalid_o(in_bvalid), .in_bid_o(in_bid),
        .in_bready_i(in_bready),
        .clint_araddr_o(clint_araddr), .clint_arvalid_o(clint_arvalid),
        .clint_arid_o(clint_arid), .clint_arlen_o(clint_arlen),
        .clint_arsize_o(clint_arsize), .clint_arburst_o(clint_arburst),
        .clint_arready_i(clint_arready),
        .clint_rdata_i(clint_rdata), .clint_rresp_i(clint_rresp),
        .clint_rvalid_i(clint_rvalid), .clint_rlast_i(clint_rlast),
        .clint_rid_i(clint_rid), .clint_rready_o(clint_rready),
        .clint_awaddr_o(clint_awaddr), .clint_awvalid_o(clint_awvalid),
        .clint_awid_o(clint_awid), .clint_awlen_o(clint_awlen),
        .clint_awsize_o(clint_awsize), .clint_awburst_o(clint_awburst),
        .clint_awready_i(clint_awready),
        .clint_wdata_o(clint_wdata), .clint_wstrb_o(clint_wstrb),
        .clint_wvalid_o(clint_wvalid), .clint_wlast_o(clint_wlast),
        .clint_wready_i(clint_wready),
        .clint_bresp_i(clint_bresp), .clint_bvalid_i(clint_bvalid),
        .clint_bid_i(clint_bid), .clint_bready_o(clint_bready),
        .soc_araddr_o(soc_araddr), .soc_arvalid_o(soc_arvalid),
        .soc_arid_o(soc_arid), .soc_arlen_o(soc_arlen),
        .soc_arsize_o(soc_arsize), .soc_arburst_o(soc_arburst),
        .soc_arready_i(soc_arready),
        .soc_rdata_i(soc_rdata), .soc_rresp_i(soc_rresp),
        .soc_rvalid_i(soc_rvalid), .soc_rlast_i(soc_rlast),
        .soc_rid_i(soc_rid), .soc_rready_o(soc_rready),
        .soc_awaddr_o(soc_awaddr), .soc_awvalid_o(soc_awvalid),
        .soc_awid_o(soc_awid), .soc_awlen_o(soc_awlen),
        .soc_awsize_o(soc_awsize), .soc_awburst_o(soc_awburst),
        .soc_awready_i(soc_awready),
        .soc_wdata_o(soc_wdata), .soc_wstrb_o(soc_wstrb),
        .soc_wvalid_o(soc_wvalid), .soc_wlast_o(soc_wlast),
        .soc_wready_i(soc_wready),
        .soc_bresp_i(soc_bresp), .soc_bvalid_i(soc_bvalid),
        .soc_bid_i(soc_bid), .soc_bready_o(soc_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to one unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_araddr = 32'h0200_0000; in_arvalid = 1'b1; clint_arready = 1'b1;
        in_awaddr = 32'h8000_0000; in_awvalid = 1'b1; soc_awready = 1'b1;
        step();
        step();
        #2;
        checks++; if (in_arready !== 1'b0) begin failures++; $display("[TB] FAIL rst_arready got=%0h exp=0", in_arready); end
        checks++; if (clint_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_clint_arvalid got=%0h exp=0", clint_arvalid); end
        checks++; if (in_awready !== 1'b0) begin failures++; $display("[TB] FAIL rst_awready got=%0h exp=0", in_awready); end
        checks++; if (soc_awvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_soc_awvalid got=%0h exp=0", soc_awvalid); end
        checks++; if (in_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rvalid got=%0h exp=0", in_rvalid); end
        checks++; if (in_bvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_bvalid got=%0h exp=0", in_bvalid); end
        checks++; if (in_wready !== 1'b0) begin failures++; $display("[TB] FAIL rst_wready got=%0h exp=0", in_wready); end
        in_arvalid = 1'b0;
        in_awvalid = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_clint_read();
        in_araddr = 32'h0200_0000; in_arid = 4'd3; in_arlen = 8'd0; in_arburst = 2'b01;
        in_arvalid = 1'b1; clint_arready = 1'b1; soc_arready = 1'b1;
        #2;
        checks++; if (clint_arvalid !== 1'b1) begin failures++; $display("[TB] FAIL crd_clint_arvalid got=%0h exp=1", clint_arvalid); end
        checks++; if (soc_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL crd_soc_arvalid got=%0h exp=0", soc_arvalid); end
        checks++; if (in_arready !== 1'b1) begin failures++; $display("[TB] FAIL crd_arready got=%0h exp=1", in_arready); end
        step();
        in_arvalid = 1'b0;
        clint_rvalid = 1'b1; clint_rdata = 32'h0000_1234; clint_rresp = 2'b00;
        clint_rlast = 1'b0; clint_rid = 4'hF; in_rready = 1'b1;
        #2;
        checks++; if (in_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL crd_rvalid got=%0h exp=1", in_rvalid); end
        checks++; if (in_rdata !== 32'h0000_1234) begin failures++; $display("[TB] FAIL crd_rdata got=%0h exp=1234", in_rdata); end
        checks++; if (in_rid !== 4'd3) begin failures++; $display("[TB] FAIL crd_rid got=%0h exp=3", in_rid); end
        checks++; if (in_rlast !== 1'b1) begin failures++; $display("[TB] FAIL crd_rlast got=%0h exp=1", in_rlast); end
        checks++; if (in_rresp !== 2'b00) begin failures++; $display("[TB] FAIL crd_rresp got=%0h exp=0", in_rresp); end
        checks++; if (clint_rready !== 1'b1) begin failures++; $display("[TB] FAIL crd_clint_rready got=%0h exp=1", clint_rready); end
        checks++; if (soc_rready !== 1'b0) begin failures++; $display("[TB] FAIL crd_soc_rready got=%0h exp=0", soc_rready); end
        checks++; if (in_arready !== 1'b0) begin failures++; $display("[TB] FAIL crd_busy_arready got=%0h exp=0", in_arready); end
        step();
        // Back in idle: a lingering slave rvalid must not leak upstream and
        // the address decoder drives arready again.
        in_araddr = 32'h8000_0000;
        #2;
        checks++; if (in_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL crd_idle_rvalid got=%0h exp=0", in_rvalid); end
        checks++; if (in_arready !== 1'b1) begin failures++; $display("[TB] FAIL crd_idle_arready got=%0h exp=1", in_arready); end
        clint_rvalid = 1'b0;
        step();
    endtask

    task automatic test_soc_burst();
        int beat;
        logic rr;
        in_araddr = 32'h8000_0000; in_arid = 4'd5; in_arlen = 8'd3; in_arburst = 2'b01;
        in_arsize = 3'd2; in_arvalid = 1'b1; soc_arready = 1'b1; clint_arready = 1'b1;
        #2;
        checks++; if (soc_arvalid !== 1'b1) begin failures++; $display("[TB] FAIL burst_soc_arvalid got=%0h exp=1", soc_arvalid); end
        checks++; if (clint_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL burst_clint_arvalid got=%0h exp=0", clint_arvalid); end
        checks++; if (soc_arlen !== 8'd3) begin failures++; $display("[TB] FAIL burst_soc_arlen got=%0h exp=3", soc_arlen); end
        step();
        // A second read to the CLINT is presented while the burst is pending.
        in_araddr = 32'h0200_0004; in_arid = 4'd6; in_arlen = 8'd0;
        beat = 0;
        for (int i = 0; i < 6; i++) begin
            rr = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            in_rready = rr;
            soc_rvalid = 1'b1; soc_rid = 4'd5; soc_rresp = 2'b00;
            soc_rdata = 32'h0000_00A0 + beat;
            soc_rlast = (beat == 3);
            #2;
            checks++; if (in_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL burst_rvalid c%0d got=%0h exp=1", i, in_rvalid); end
            checks++; if (in_rdata !== 32'h0000_00A0 + beat) begin failures++; $display("[TB] FAIL burst_rdata c%0d got=%0h exp=%0h", i, in_rdata, 32'h0000_00A0 + beat); end
            checks++; if (in_rid !== 4'd5) begin failures++; $display("[TB] FAIL burst_rid c%0d got=%0h exp=5", i, in_rid); end
            checks++; if (in_rlast !== (beat == 3)) begin failures++; $display("[TB] FAIL burst_rlast c%0d got=%0h exp=%0h", i, in_rlast, (beat == 3)); end
            checks++; if (soc_rready !== rr) begin failures++; $display("[TB] FAIL burst_soc_rready c%0d got=%0h exp=%0h", i, soc_rready, rr); end
            checks++; if (clint_rready !== 1'b0) begin failures++; $display("[TB] FAIL burst_clint_rready c%0d got=%0h exp=0", i, clint_rready); end
            checks++; if (in_arready !== 1'b0) begin failures++; $display("[TB] FAIL burst_pend_arready c%0d got=%0h exp=0", i, in_arready); end
            checks++; if (clint_arvalid !== 1'b0) begin failures++; $display("[TB] FAIL burst_pend_clint_arvalid c%0d got=%0h exp=0", i, clint_arvalid); end
            step();
            if (rr) beat++;
        end
        soc_rvalid = 1'b0; soc_rlast = 1'b0;
        #2;
        checks++; if (clint_arvalid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_clint_arvalid got=%0h exp=1", clint_arvalid); end
        checks++; if (in_arready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_arready got=%0h exp=1", in_arready); end
        step();
        in_arvalid = 1'b0;
        clint_rvalid = 1'b1; clint_rdata = 32'h0000_5678; clint_rid = 4'h0; in_rready = 1'b1;
        #2;
        checks++; if (in_rdata !== 32'h0000_5678) begin failures++; $display("[TB] FAIL b2b_rdata got=%0h exp=5678", in_rdata); end
        checks++; if (in_rid !== 4'd6) begin failures++; $display("[TB] FAIL b2b_rid got=%0h exp=6", in_rid); end
        step();
        clint_rvalid = 1'b0;
        step();
    endtask

    task automatic test_soc_write();
        in_wvalid = 1'b1; in_wdata = 32'hDEAD_BEEF; in_wstrb = 4'hF; in_wlast = 1'b1;
        soc_wready = 1'b1; clint_wready = 1'b1; in_awvalid = 1'b0;
        #2;
        checks++; if (in_wready !== 1'b0) begin failures++; $display("[TB] FAIL wr_early_wready got=%0h exp=0", in_wready); end
        checks++; if (soc_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_early_soc_wvalid got=%0h exp=0", soc_wvalid); end
        step();
        in_awaddr = 32'h8000_0010; in_awid = 4'd2; in_awlen = 8'd0; in_awburst = 2'b01;
        in_awvalid = 1'b1; soc_awready = 1'b1; clint_awready = 1'b1;
        #2;
        checks++; if (soc_awvalid !== 1'b1) begin failures++; $display("[TB] FAIL wr_soc_awvalid got=%0h exp=1", soc_awvalid); end
        checks++; if (clint_awvalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_clint_awvalid got=%0h exp=0", clint_awvalid); end
        checks++; if (soc_awaddr !== 32'h8000_0010) begin failures++; $display("[TB] FAIL wr_soc_awaddr got=%0h exp=80000010", soc_awaddr); end
        checks++; if (soc_awid !== 4'd2) begin failures++; $display("[TB] FAIL wr_soc_awid got=%0h exp=2", soc_awid); end
        checks++; if (in_awready !== 1'b1) begin failures++; $display("[TB] FAIL wr_awready got=%0h exp=1", in_awready); end
        step();
        in_awvalid = 1'b0;
        #2;
        checks++; if (in_wready !== 1'b1) begin failures++; $display("[TB] FAIL wr_wready got=%0h exp=1", in_wready); end
        checks++; if (soc_wvalid !== 1'b1) begin failures++; $display("[TB] FAIL wr_soc_wvalid got=%0h exp=1", soc_wvalid); end
        checks++; if (soc_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wr_soc_wdata got=%0h exp=deadbeef", soc_wdata); end
        checks++; if (soc_wstrb !== 4'hF) begin failures++; $display("[TB] FAIL wr_soc_wstrb got=%0h exp=f", soc_wstrb); end
        checks++; if (clint_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_clint_wvalid got=%0h exp=0", clint_wvalid); end
        step();
        in_wvalid = 1'b0;
        soc_bvalid = 1'b1; soc_bresp = 2'b00; soc_bid = 4'd2; in_bready = 1'b1;
        #2;
        checks++; if (in_bvalid !== 1'b1) begin failures++; $display("[TB] FAIL wr_bvalid got=%0h exp=1", in_bvalid); end
        checks++; if (in_bresp !== 2'b00) begin failures++; $display("[TB] FAIL wr_bresp got=%0h exp=0", in_bresp); end
        checks++; if (in_bid !== 4'd2) begin failures++; $display("[TB] FAIL wr_bid got=%0h exp=2", in_bid); end
        checks++; if (soc_bready !== 1'b1) begin failures++; $display("[TB] FAIL wr_soc_bready got=%0h exp=1", soc_bready); end
        step();
        #2;
        checks++; if (in_bvalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_idle_bvalid got=%0h exp=0", in_bvalid); end
        soc_bvalid = 1'b0;
        step();
    endtask

    task automatic test_clint_write();
        in_awaddr = 32'h0200_0004; in_awid = 4'd7; in_awvalid = 1'b1;
        clint_awready = 1'b1; soc_awready = 1'b1; in_bready = 1'b0;
`ifdef YSYX_24100029_CLINT_WPROT_EN
        #2;
        checks++; if (clint_awvalid !== 1'b0) begin failures++; $display("[TB] FAIL cwp_clint_awvalid got=%0h exp=0", clint_awvalid); end
        checks++; if (in_awready !== 1'b1) begin failures++; $display("[TB] FAIL cwp_awready got=%0h exp=1", in_awready); end
        step();
        in_awvalid = 1'b0;
        in_wvalid = 1'b1; in_wdata = 32'h0000_0001; in_wstrb = 4'hF; in_wlast = 1'b1;
        #2;
        checks++; if (in_wready !== 1'b1) begin failures++; $display("[TB] FAIL cwp_wready got=%0h exp=1", in_wready); end
        checks++; if (clint_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL cwp_clint_wvalid got=%0h exp=0", clint_wvalid); end
        checks++; if (in_bvalid !== 1'b0) begin failures++; $display("[TB] FAIL cwp_early_bvalid got=%0h exp=0", in_bvalid); end
        step();
        in_wvalid = 1'b0;
        #2;
        checks++; if (in_bvalid !== 1'b1) begin failures++; $display("[TB] FAIL cwp_bvalid got=%0h exp=1", in_bvalid); end
        checks++; if (in_bresp !== 2'b10) begin failures++; $display("[TB] FAIL cwp_bresp got=%0h exp=2", in_bresp); end
        checks++; if (in_bid !== 4'd7) begin failures++; $display("[TB] FAIL cwp_bid got=%0h exp=7", in_bid); end
        step();
        #2;
        checks++; if (in_bvalid !== 1'b1) begin failures++; $display("[TB] FAIL cwp_hold_bvalid got=%0h exp=1", in_bvalid); end
        in_bready = 1'b1;
        step();
        #2;
        checks++; if (in_bvalid !== 1'b0) begin failures++; $display("[TB] FAIL cwp_done_bvalid got=%0h exp=0", in_bvalid); end
`else
        #2;
        checks++; if (clint_awvalid !== 1'b1) begin failures++; $display("[TB] FAIL cw_clint_awvalid got=%0h exp=1", clint_awvalid); end
        checks++; if (soc_awvalid !== 1'b0) begin failures++; $display("[TB] FAIL cw_soc_awvalid got=%0h exp=0", soc_awvalid); end
        checks++; if (clint_awaddr !== 32'h0200_0004) begin failures++; $display("[TB] FAIL cw_clint_awaddr got=%0h exp=2000004", clint_awaddr); end
        step();
        in_awvalid = 1'b0;
        in_wvalid = 1'b1; in_wdata = 32'h0000_0001; in_wstrb = 4'hF; in_wlast = 1'b1;
        #2;
        checks++; if (clint_wvalid !== 1'b1) begin failures++; $display("[TB] FAIL cw_clint_wvalid got=%0h exp=1", clint_wvalid); end
        checks++; if (soc_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL cw_soc_wvalid got=%0h exp=0", soc_wvalid); end
        checks++; if (in_wready !== 1'b1) begin failures++; $display("[TB] FAIL cw_wready got=%0h exp=1", in_wready); end
        step();
        in_wvalid = 1'b0;
        clint_bvalid = 1'b1; clint_bresp = 2'b00; clint_bid = 4'd7; in_bready = 1'b1;
        #2;
        checks++; if (in_bvalid !== 1'b1) begin failures++; $display("[TB] FAIL cw_bvalid got=%0h exp=1", in_bvalid); end
        checks++; if (in_bid !== 4'd7) begin failures++; $display("[TB] FAIL cw_bid got=%0h exp=7", in_bid); end
        checks++; if (clint_bready !== 1'b1) begin failures++; $display("[TB] FAIL cw_clint_bready got=%0h exp=1", clint_bready); end
        step();
        clint_bvalid = 1'b0;
`endif
        step();
    endtask

    task automatic test_reset_mid_burst();
        in_araddr = 32'h8000_0000; in_arid = 4'd5; in_arlen = 8'd3; in_arvalid = 1'b1;
        soc_arready = 1'b1;
        step();
        in_arvalid = 1'b0;
        soc_rvalid = 1'b1; soc_rid = 4'd5; soc_rlast = 1'b0; soc_rdata = 32'h0000_0B00;
        in_rready = 1'b1;
        step();
        soc_rdata = 32'h0000_0B01;
        reset = 1'b1;
        #2;
        checks++; if (in_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmb_in_reset_rvalid got=%0h exp=0", in_rvalid); end
        checks++; if (soc_rready !== 1'b0) begin failures++; $display("[TB] FAIL rmb_in_reset_soc_rready got=%0h exp=0", soc_rready); end
        step();
        reset = 1'b0;
        #2;
        checks++; if (in_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmb_after_rvalid got=%0h exp=0", in_rvalid); end
        checks++; if (soc_rready !== 1'b0) begin failures++; $display("[TB] FAIL rmb_after_soc_rready got=%0h exp=0", soc_rready); end
        soc_rvalid = 1'b0;
        in_araddr = 32'h0200_0000; in_arid = 4'd9; in_arlen = 8'd0; in_arvalid = 1'b1;
        clint_arready = 1'b1;
        #1;
        checks++; if (clint_arvalid !== 1'b1) begin failures++; $display("[TB] FAIL rmb_clint_arvalid got=%0h exp=1", clint_arvalid); end
        checks++; if (in_arready !== 1'b1) begin failures++; $display("[TB] FAIL rmb_arready got=%0h exp=1", in_arready); end
        step();
        in_arvalid = 1'b0;
        clint_rvalid = 1'b1; clint_rdata = 32'h0000_0042;
        #2;
        checks++; if (in_rid !== 4'd9) begin failures++; $display("[TB] FAIL rmb_rid got=%0h exp=9", in_rid); end
        checks++; if (in_rdata !== 32'h0000_0042) begin failures++; $display("[TB] FAIL rmb_rdata got=%0h exp=42", in_rdata); end
        step();
        clint_rvalid = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_araddr = '0; in_arvalid = 1'b0; in_arid = '0; in_arlen = '0;
        in_arsize = 3'd2; in_arburst = 2'b01; in_rready = 1'b0;
        in_awaddr = '0; in_awvalid = 1'b0; in_awid = '0; in_awlen = '0;
        in_awsize = 3'd2; in_awburst = 2'b01;
        in_wdata = '0; in_wstrb = '0; in_wvalid = 1'b0; in_wlast = 1'b0; in_bready = 1'b0;
        clint_arready = 1'b0; clint_rdata = '0; clint_rresp = '0; clint_rvalid = 1'b0;
        clint_rlast = 1'b0; clint_rid = '0; clint_awready = 1'b0; clint_wready = 1'b0;
        clint_bresp = '0; clint_bvalid = 1'b0; clint_bid = '0;
        soc_arready = 1'b0; soc_rdata = '0; soc_rresp = '0; soc_rvalid = 1'b0;
        soc_rlast = 1'b0; soc_rid = '0; soc_awready = 1'b0; soc_wready = 1'b0;
        soc_bresp = '0; soc_bvalid = 1'b0; soc_bid = '0;

        $display("[TB] starting xbar directed tests");
        test_reset();
        test_clint_read();
        test_soc_burst();
        test_soc_write();
        test_clint_write();
        test_reset_mid_burst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/ysyx_24100029_xbar.md
# ysyx_24100029_xbar

AXI4 1-to-2 crossbar directly upstream of the CLINT. It takes the core's single AXI4 master port (LSU/IFU arbiter output) and routes each transaction either to the CLINT slave or to the default SoC slave, muxing responses back. At most one read and one write are outstanding. The crossbar fills in the `rlast`/`rid` fields that the single-beat CLINT does not drive.

## Interface
- CLINT_BASE, 32'h0200_0000, CLINT region base.
- CLINT_MASK, 32'hFFFF_0000, region match mask: hit when (addr & CLINT_MASK) == CLINT_BASE.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_araddr/arvalid/arid/arlen/arsize/arburst  in  32/1/4/8/3/2  upstream AR
- in_arready  out  1  upstream AR ready
- in_rdata/rresp/rvalid/rlast/rid  out  32/2/1/1/4  upstream R
- in_rready  in  1  upstream R ready
- in_awaddr/awvalid/awid/awlen/awsize/awburst  in  32/1/4/8/3/2  upstream AW
- in_awready  out  1  upstream AW ready
- in_wdata/wstrb/wvalid/wlast  in  32/4/1/1  upstream W
- in_wready  out  1  upstream W ready
- in_bresp/bvalid/bid  out  2/1/4  upstream B
- in_bready  in  1  upstream B ready
- clint_* and soc_*  full AXI4 master port sets, same widths, opposite directions to the in_* ports. clint_rlast and clint_rid are ignored.

## Operation
- Read FSM states: R_IDLE, R_CLINT, R_SOC.
  - In R_IDLE, in_araddr is decoded combinationally. Only the selected slave's arvalid follows in_arvalid; in_arready = selected slave's arready.
  - On the AR handshake: latch arid, then go to R_CLINT or R_SOC.
- In R_CLINT / R_SOC:
  - in_arready=0; both slave arvalids are 0.
  - R channel is routed from the selected slave; rready is routed to it only; the other slave sees rready=0.
  - In R_CLINT: in_rlast=1 and in_rid=latched arid.
  - In R_SOC: rlast and rid pass through unchanged.
- Return to R_IDLE on in_rvalid & in_rready & in_rlast.
- Write FSM states: W_IDLE, W_CLINT, W_SOC, W_ERR.
  - AW is decoded and handshaked the same way as AR; awid is latched.
  - In W_IDLE, in_wready=0 (W is held until AW is accepted).
  - In W_CLINT / W_SOC: W and B are routed to and from the target. Return to W_IDLE on in_bvalid & in_bready.
- Read and write FSMs are independent; a concurrent read and write to different slaves is legal.
- Reset: both FSMs go to idle. All in_*valid/ready outputs are 0 during reset except the combinational idle-state readys (which are gated to 0 while reset=1). In-flight transactions are dropped with no response.

## Timing
- Routing is zero-latency. Valid, ready and data are combinational through the crossbar in every state, so no bubble is added.
- The earliest R beat is the cycle after the AR handshake (FSM register update).
- Back-to-back: a new AR is accepted in the cycle after the rlast handshake. One idle cycle is mandatory.
- W_ERR (see Configuration): in_wready=1 for every beat. The B response is registered: in_bvalid rises the cycle after the wlast beat handshake, with bresp=2'b10 and bid=latched awid, and holds until in_bready.

## Configuration
- YSYX_24100029_CLINT_WPROT_EN defined:
  - An AW hitting the CLINT region is accepted locally (in_awready=1, clint_awvalid stays 0) and the FSM goes to W_ERR.
  - W beats are sunk and SLVERR (2'b10) is returned. The CLINT never sees writes.
- Macro undefined: there is no W_ERR state, and CLINT-region writes are forwarded to the clint_* port like any other write.

## Test plan
- Read 0x0200_0000, arid=3:
  - clint_arvalid=1, soc_arvalid=0.
  - CLINT returns rdata=0x1234 → in_rdata=0x1234, rid=3, rlast=1, rresp=0. FSM back to R_IDLE next cycle.
- Read 0x8000_0000, arlen=3, INCR, arid=5:
  - Routed to SoC; 4 beats pass through with rid=5; rlast only on beat 4.
  - With in_rready low for 2 cycles mid-burst, soc_rready is low for the same cycles.
- Second AR (0x0200_0004) issued while the SoC read is pending:
  - in_arready=0 until the cycle after the rlast handshake, then routed to CLINT.
- Write 0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, awid=2:
  - soc_* sees an identical AW/W; soc bresp=0 → in_bresp=0, in_bid=2.
  - W presented before AW sees in_wready=0.
- Write 0x0200_0004, awid=7:
  - With macro: clint_awvalid stays 0; bvalid rises 1 cycle after wlast with bresp=2'b10, bid=7.
  - Without macro: forwarded to clint_*.
- reset pulsed for 1 cycle during beat 2 of a 4-beat SoC read:
  - Next cycle in_rvalid=0 and the FSM is in R_IDLE.
  - A new AR to 0x0200_0000 is accepted normally.
